quad_encoder_gen: RTL and testbench

- Generates quadrature A/B signals for a commanded number of edges, at a commanded edge period and direction.
- Transmit-side counterpart of quadrature_decoder. Used for hardware-in-loop and self-test on the motor board.
- Outputs can drive the ENCODER0/ENCODER1 nets of a second board, or loop back internally into quadrature_decoder.
- Commands are accepted over a valid/ready handshake, so coms or a test FSM can queue motion profiles.

---
 rtl/quad_encoder_gen_pkg.sv | 7 +
 rtl/quad_encoder_gen_edge_timer.sv | 29 ++
 rtl/quad_encoder_gen.sv | 84 ++++++++
 tb/tb_quad_encoder_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// quad_encoder_gen_pkg: shared state encoding, phase table and defaults for the quadrature generator.
package quad_encoder_gen_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int MIN_EDGE_CYCLES_DEF = 2;
    // {a,b} per phase; adjacent entries differ in one bit
    localparam logic [1:0] PHASE_AB [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
endpackage

// File: rtl/quad_encoder_gen_edge_timer.sv
// quad_encoder_gen_edge_timer: loadable down-counter that pulses expire once per latched period.
module quad_encoder_gen_edge_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                load,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                expire
);
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] reload;
    assign expire = en && cnt == PERIOD_W'(1);
    // The load cycle itself counts as the first cycle of the first interval
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            cnt    <= '0;
            reload <= '0;
        end else if (load) begin
            reload <= period;
            cnt    <= period - PERIOD_W'(1);
        end else if (expire) begin
            cnt <= reload;
        end else if (en) begin
            cnt <= cnt - PERIOD_W'(1);
        end
    end
endmodule

// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: emits a commanded number of quadrature A/B edges at a commanded period and direction.
module quad_encoder_gen
    import quad_encoder_gen_pkg::*;
#(
    parameter int MIN_EDGE_CYCLES = MIN_EDGE_CYCLES_DEF,
    parameter int STEP_W          = 32,
    parameter int PERIOD_W        = 24
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic signed [STEP_W-1:0] cmd_steps,
    input  logic [PERIOD_W-1:0]      cmd_period,
    input  logic                     abort,
    output logic                     a,
    output logic                     b,
    output logic                     busy,
    output logic                     done,
    output logic signed [STEP_W-1:0] position
);
    state_t              state;
    logic [1:0]          phase;
    logic [1:0]          phase_nxt;
    logic                dir;
    logic [STEP_W:0]     remaining;
    logic [STEP_W:0]     steps_ext;
    logic [STEP_W:0]     steps_mag;
    logic [PERIOD_W-1:0] period_eff;
    logic                load;
    logic                tick_en;
    logic                expire;

    // One extra bit so the most-negative count has a representable magnitude
    assign steps_ext  = {cmd_steps[STEP_W-1], cmd_steps};
    assign steps_mag  = cmd_steps[STEP_W-1] ? -steps_ext : steps_ext;
    assign period_eff = cmd_period < PERIOD_W'(MIN_EDGE_CYCLES) ? PERIOD_W'(MIN_EDGE_CYCLES) : cmd_period;
    assign load       = state == IDLE && cmd_valid;
    assign tick_en    = state == RUN && !abort && remaining != '0;
    assign phase_nxt  = dir ? phase + 2'd1 : phase - 2'd1;
    assign cmd_ready  = state == IDLE;
    assign busy       = state == RUN;
    assign done       = state == DONE;

    quad_encoder_gen_edge_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .CLK     (CLK),
        .reset_n (reset_n),
        .load    (load),
        .en      (tick_en),
        .period  (period_eff),
        .expire  (expire)
    );

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase     <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            position  <= '0;
            remaining <= '0;
            dir       <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (cmd_valid) begin
                    remaining <= steps_mag;
                    dir       <= ~cmd_steps[STEP_W-1];
                    state     <= steps_mag == '0 ? DONE : RUN;
                end
                // Abort wins over an edge due in the same cycle
                RUN: if (abort || remaining == '0) begin
                    state <= DONE;
                end else if (expire) begin
                    phase     <= phase_nxt;
                    {a, b}    <= PHASE_AB[phase_nxt];
                    position  <= dir ? position + STEP_W'(1) : position - STEP_W'(1);
                    remaining <= remaining - (STEP_W+1)'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb_quad_encoder_gen: scoreboard bench; a timeline model predicts every A/B edge and done pulse.
module tb_quad_encoder_gen;
    typedef struct {
        int          t;
        logic [1:0]  ab;
        logic [31:0] pos;
        bit          dn;
    } ev_t;

    logic               CLK = 1'b0;
    logic               reset_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic signed [31:0] cmd_steps = '0;
    logic [23:0]        cmd_period = '0;
    logic               abort = 1'b0;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;
    logic signed [31:0] position;

    ev_t        q[$];
    ev_t        mev;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         m_phase = 0;
    int         m_pos = 0;
    bit         mon_off = 1'b1;
    logic [1:0] prev_ab = 2'b00;

    quad_encoder_gen dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Gray-code position of each phase: a high in phases 1,2; b high in phases 2,3
    function automatic logic [1:0] ab_of(input int p);
        return {logic'(p == 1 || p == 2), logic'(p >= 2)};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (!mon_off && ({a, b} != prev_ab || done)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cycle=%0d ab=%b done=%b pos=%0d", cyc, {a, b}, done, position);
            end else begin
                mev = q.pop_front();
                if (mev.t != cyc || mev.ab != {a, b} || mev.pos != position || mev.dn != done || busy == mev.dn) begin
                    errors++;
                    $display("FAIL event got cycle=%0d ab=%b pos=%0d done=%b busy=%b expected cycle=%0d ab=%b pos=%0d done=%b busy=%b",
                             cyc, {a, b}, position, done, busy, mev.t, mev.ab, $signed(mev.pos), mev.dn, !mev.dn);
                end
            end
        end
        prev_ab = {a, b};
    end

    task automatic push_edge(input int t, input int dir);
        ev_t e;
        m_phase = (m_phase + dir) & 3;
        m_pos  += dir;
        e.t = t; e.ab = ab_of(m_phase); e.pos = m_pos; e.dn = 1'b0;
        q.push_back(e);
    endtask

    task automatic wait_ready();
        int bound = 0;
        while (!cmd_ready && bound < 500) begin
            @(posedge CLK); #1;
            bound++;
        end
        chk("ready_wait", cmd_ready, 1);
    endtask

    task automatic run_cmd(input int steps, input int period, input int abort_k, input bit hold, input bit abort_acc);
        int  pe, n, dir, t0, tdone, last;
        ev_t e;
        wait_ready();
        cmd_valid = 1'b1; cmd_steps = steps; cmd_period = 24'(period); abort = abort_acc;
        t0    = cyc;
        pe    = period < 2 ? 2 : period;
        n     = steps < 0 ? -steps : steps;
        dir   = steps < 0 ? -1 : 1;
        last  = abort_k > 0 ? abort_k - 1 : n;
        for (int k = 1; k <= last; k++) push_edge(t0 + k * pe, dir);
        tdone = abort_k > 0 ? t0 + abort_k * pe : t0 + n * pe + 1;
        e.t = tdone; e.ab = ab_of(m_phase); e.pos = m_pos; e.dn = 1'b1;
        q.push_back(e);
        @(posedge CLK); #1;
        abort = 1'b0;
        if (!hold) cmd_valid = 1'b0;
        while (cyc <= tdone) begin
            abort = abort_k > 0 && cyc == t0 + abort_k * pe - 1;
            if (cyc == tdone) cmd_valid = 1'b0;
            @(posedge CLK); #1;
        end
        abort = 1'b0; cmd_valid = 1'b0;
        chk("ready_after_done", cmd_ready, 1);
        chk("queue_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic reset_mid();
        int t0;
        wait_ready();
        cmd_valid = 1'b1; cmd_steps = 20; cmd_period = 24'd3;
        t0 = cyc;
        for (int k = 1; k <= 5; k++) push_edge(t0 + k * 3, 1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        while (cyc < t0 + 16) begin
            @(posedge CLK); #1;
        end
        chk("mid_edges_seen", q.size(), 0);
        mon_off = 1'b1;
        reset_n = 1'b0;
        @(posedge CLK); #1;
        reset_n = 1'b1;
        chk("mid_rst_a", a, 0);
        chk("mid_rst_b", b, 0);
        chk("mid_rst_pos", position, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        m_phase = 0; m_pos = 0;
        q.delete();
        @(negedge CLK);
        mon_off = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int steps, period, n, abort_k;
        repeat (3) @(posedge CLK);
        #1;
        reset_n = 1'b1;
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_pos", position, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        mon_off = 1'b0;
        run_cmd(8, 4, 0, 1'b0, 1'b0);
        chk("pos_after_fwd8", position, 8);
        run_cmd(-4, 10, 0, 1'b0, 1'b0);
        chk("pos_after_rev4", position, 4);
        run_cmd(3, 0, 0, 1'b0, 1'b0);
        run_cmd(0, 7, 0, 1'b1, 1'b0);
        run_cmd(5, 3, 0, 1'b1, 1'b1);
        run_cmd(100, 5, 4, 1'b0, 1'b0);
        chk("abort_ab", {a, b}, ab_of(m_phase));
        chk("abort_pos", position, m_pos);
        reset_mid();
        for (int i = 0; i < 12; i++) begin
            steps   = int'($urandom_range(0, 24)) - 12;
            period  = int'($urandom_range(0, 6));
            n       = steps < 0 ? -steps : steps;
            abort_k = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
            run_cmd(steps, period, abort_k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("final_pos", position, m_pos);
        chk("final_ab", {a, b}, ab_of(m_phase));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
